seg_scan_driver: RTL and testbench
==================================

Name: seg_scan_driver

Overview:
- Time-multiplexed 8-digit seven-segment display driver; sits directly downstream of the 8-digit BCD stopwatch counter.
- Drives the counter's 3-bit digit-select input and samples its combinational 4-bit digit output.
- Decodes the sampled digit and drives common-anode segment and digit-enable lines, with anti-ghosting blanking, leading-zero suppression and per-digit decimal points.

Parameters:
- SCAN_DIV, 8, clk cycles per digit slot; legal range 2..2^20.
- BLANK_CYC, 2, cycles at the start of each slot with all digits off; legal range 1..SCAN_DIV-1.

Ports:
- clk  in  1  system clock.
- rst  in  1  asynchronous, active-high reset.
- en  in  1  display enable; 0 blanks the display and parks the scan.
- lz_en  in  1  leading-zero suppression enable.
- dp_mask  in  8  bit i lights the decimal point of slot i.
- digit_in  in  4  BCD digit from the counter for the current sel; 4'hF means the counter is disabled.
- sel  out  3  digit select to the counter; slot 0 is leftmost (most significant).
- seg  out  7  {g,f,e,d,c,b,a}, active-low.
- dp  out  1  decimal point, active-low.
- an  out  8  digit enables, active-low; an[i] = slot i.
- frame_tick  out  1  one-cycle pulse when slot wraps from 7 to 0.

Behaviour:
- Reset values: sel=0, seg=7'h7F, dp=1, an=8'hFF, frame_tick=0. Internal state: div_cnt=0, state=BLANK, lz_flag=1, dig_q=4'hF.
- All outputs are registered. sel equals the current slot.
- div_cnt counts 0..SCAN_DIV-1 within each slot.
- State BLANK, div_cnt < BLANK_CYC:
  - an=8'hFF, seg=7'h7F, dp=1.
  - sel is stable, so the counter output settles during this window.
  - On div_cnt==BLANK_CYC-1, capture digit_in into dig_q and evaluate suppression.
  - Next state is SHOW.
- State SHOW:
  - an has only bit[sel] low.
  - seg=decode(dig_q), or 7'h7F if the digit is suppressed.
  - dp=~dp_mask[sel].
- End of slot, div_cnt==SCAN_DIV-1:
  - div_cnt=0; sel=sel+1, wrapping 7->0; state=BLANK.
  - On the wrap, frame_tick=1 for exactly that cycle and lz_flag is set to 1.
- Leading-zero suppression, evaluated at capture:
  - Suppress if lz_en=1, lz_flag=1, captured digit==0 and sel!=7.
  - Otherwise clear lz_flag.
  - Slot 7 is never suppressed, so "0" always shows.
- Decode table (active-low):
  - 0=40, 1=79, 2=24, 3=30, 4=19, 5=12, 6=02, 7=78, 8=00, 9=10.
  - 10..14 give dash 3F (g only).
  - 15 gives blank 7F.
- en=0, synchronous effect next edge:
  - div_cnt=0, sel=0, state=BLANK, lz_flag=1.
  - an=8'hFF, seg=7'h7F, dp=1, frame_tick=0.
  - Re-assertion of en restarts at slot 0 BLANK.
- Changes to dp_mask take effect on the next cycle. Changes to lz_en take effect at the next capture.
- Frame period is 8*SCAN_DIV cycles. Each digit is lit for SCAN_DIV-BLANK_CYC cycles.
- Asynchronous rst mid-slot returns every register to its reset value immediately. Scanning resumes at slot 0 on the first edge after release.

Decomposition:
- Package seg7_pkg holds:
  - the segment constants SEG_0..SEG_9, SEG_DASH, SEG_BLANK;
  - the state enum {BLANK, SHOW};
  - NUM_DIGITS=8.
- Sub-module bcd_to_seg7 is a combinational 4-bit to 7-bit decoder, instantiated once on dig_q.

Test Plan:
- Reset, then release with en=1, SCAN_DIV=8, BLANK_CYC=2 -> sel steps 0..7 every 8 cycles; an low 6 of 8 cycles per slot; frame_tick high once per 64 cycles.
- Model counter holds digits 1,2,3,4,5,6,7,8, lz_en=0 -> seg shows 79,24,30,19,12,02,78,00 on an[0]..an[7] respectively.
- Digits 0,0,0,5,0,0,0,0 with lz_en=1 -> slots 0-2 blank (seg 7F, an still pulses); slot 3 shows 12; slots 4-7 show 40.
- All digits 0, lz_en=1 -> slots 0-6 blank, slot 7 shows 40. digit_in=4'hF on all slots -> all blank.
- dp_mask=8'b0010_1000 -> dp low only during SHOW of slots 3 and 5.
- en dropped mid-slot 4 -> next cycle an=FF and sel=0; re-enable restarts at slot 0. Async rst asserted mid-SHOW -> outputs go to reset values with no clock edge.

Source files
------------

// File: rtl/seg7_pkg.sv
// seg7_pkg: shared constants and state type for the seven-segment scan driver.
`default_nettype none

package seg7_pkg;

   localparam int NUM_DIGITS = 8;

   // Active-low {g,f,e,d,c,b,a} patterns for a common-anode display
   localparam logic [6:0] SEG_0     = 7'h40;
   localparam logic [6:0] SEG_1     = 7'h79;
   localparam logic [6:0] SEG_2     = 7'h24;
   localparam logic [6:0] SEG_3     = 7'h30;
   localparam logic [6:0] SEG_4     = 7'h19;
   localparam logic [6:0] SEG_5     = 7'h12;
   localparam logic [6:0] SEG_6     = 7'h02;
   localparam logic [6:0] SEG_7     = 7'h78;
   localparam logic [6:0] SEG_8     = 7'h00;
   localparam logic [6:0] SEG_9     = 7'h10;
   localparam logic [6:0] SEG_DASH  = 7'h3F;
   localparam logic [6:0] SEG_BLANK = 7'h7F;

   typedef enum logic [0:0] {
      BLANK = 1'b0,
      SHOW  = 1'b1
   } state_t;

endpackage

`default_nettype wire

// File: rtl/bcd_to_seg7.sv
// bcd_to_seg7: combinational BCD to active-low seven-segment decoder.
`default_nettype none

module bcd_to_seg7
   import seg7_pkg::*;
(
   input  logic [3:0] bcd,
   output logic [6:0] seg
);

   always_comb begin
      seg = SEG_BLANK;
      case (bcd)
         4'd0:    seg = SEG_0;
         4'd1:    seg = SEG_1;
         4'd2:    seg = SEG_2;
         4'd3:    seg = SEG_3;
         4'd4:    seg = SEG_4;
         4'd5:    seg = SEG_5;
         4'd6:    seg = SEG_6;
         4'd7:    seg = SEG_7;
         4'd8:    seg = SEG_8;
         4'd9:    seg = SEG_9;
         4'hF:    seg = SEG_BLANK;
         default: seg = SEG_DASH;
      endcase
   end

endmodule

`default_nettype wire

// File: rtl/seg_scan_driver.sv
// seg_scan_driver: 8-digit multiplexed common-anode display scanner with
// anti-ghost blanking, leading-zero suppression and per-digit decimal points.
`default_nettype none

module seg_scan_driver
   import seg7_pkg::*;
#(
   parameter int SCAN_DIV  = 8,
   parameter int BLANK_CYC = 2
)(
   input  logic       clk,
   input  logic       rst,
   input  logic       en,
   input  logic       lz_en,
   input  logic [7:0] dp_mask,
   input  logic [3:0] digit_in,
   output logic [2:0] sel,
   output logic [6:0] seg,
   output logic       dp,
   output logic [7:0] an,
   output logic       frame_tick
);

   localparam int            CW       = $clog2(SCAN_DIV);
   localparam logic [CW-1:0] CNT_LAST = CW'(SCAN_DIV - 1);
   localparam logic [CW-1:0] CAP_AT   = CW'(BLANK_CYC - 1);
   localparam logic [2:0]    LAST_SEL = 3'(NUM_DIGITS - 1);

   logic [CW-1:0] div_cnt, div_d;
   state_t        state, state_d;
   logic [2:0]    sel_d;
   logic          lz_flag, lz_d;
   logic [3:0]    dig_q, dig_d;
   logic [6:0]    seg_d, dec_seg;
   logic          dp_d, ft_d, suppress, capture;
   logic [7:0]    an_d;

   // Outputs are registered, so the decoder looks at the value dig_q is about
   // to take; this lets the segments be valid on the very first lit cycle.
   assign capture = en && (div_cnt == CAP_AT);
   assign dig_d   = capture ? digit_in : dig_q;

   bcd_to_seg7 u_dec (
      .bcd (dig_d),
      .seg (dec_seg)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         div_cnt    <= '0;
         state      <= BLANK;
         sel        <= 3'd0;
         lz_flag    <= 1'b1;
         dig_q      <= 4'hF;
         seg        <= SEG_BLANK;
         dp         <= 1'b1;
         an         <= 8'hFF;
         frame_tick <= 1'b0;
      end else begin
         div_cnt    <= div_d;
         state      <= state_d;
         sel        <= sel_d;
         lz_flag    <= lz_d;
         dig_q      <= dig_d;
         seg        <= seg_d;
         dp         <= dp_d;
         an         <= an_d;
         frame_tick <= ft_d;
      end
   end

   always_comb begin
      div_d    = div_cnt;
      state_d  = state;
      sel_d    = sel;
      lz_d     = lz_flag;
      seg_d    = seg;
      dp_d     = dp;
      an_d     = an;
      ft_d     = 1'b0;
      suppress = 1'b0;

      if (!en) begin
         div_d   = '0;
         sel_d   = 3'd0;
         state_d = BLANK;
         lz_d    = 1'b1;
         an_d    = 8'hFF;
         seg_d   = SEG_BLANK;
         dp_d    = 1'b1;
      end else if (div_cnt == CNT_LAST) begin
         div_d   = '0;
         sel_d   = sel + 3'd1;
         state_d = BLANK;
         an_d    = 8'hFF;
         seg_d   = SEG_BLANK;
         dp_d    = 1'b1;
         if (sel == LAST_SEL) begin
            ft_d = 1'b1;
            lz_d = 1'b1;
         end
      end else begin
         div_d = div_cnt + 1'b1;
         if (capture) begin
            // The rightmost digit is never suppressed so a zero value still reads "0"
            suppress = lz_en && lz_flag && (digit_in == 4'd0) && (sel != LAST_SEL);
            if (!suppress)
               lz_d = 1'b0;
            state_d = SHOW;
            seg_d   = suppress ? SEG_BLANK : dec_seg;
         end
         if (state_d == SHOW) begin
            an_d = ~(8'd1 << sel);
            dp_d = ~dp_mask[sel];
         end
      end
   end

endmodule

`default_nettype wire

// File: tb/tb_seg_scan_driver.sv
// tb_seg_scan_driver: randomized and directed checks of the scan driver against
// a cycle-indexed behavioural model of the display.
`default_nettype none

module tb_seg_scan_driver;

   localparam int SD = 8;
   localparam int BC = 2;
   localparam logic [19:0] RESET_VEC = {3'd0, 8'hFF, 7'h7F, 1'b1, 1'b0};

   logic       clk, rst, en, lz_en;
   logic [7:0] dp_mask;
   logic [3:0] digit_in;
   logic [2:0] sel;
   logic [6:0] seg;
   logic       dp;
   logic [7:0] an;
   logic       frame_tick;

   logic [3:0] digits [8];
   int checks   = 0;
   int failures = 0;

   // Model of the upstream counter: combinational digit for the selected slot
   assign digit_in = digits[sel];

   seg_scan_driver #(.SCAN_DIV(SD), .BLANK_CYC(BC)) dut (
      .clk        (clk),
      .rst        (rst),
      .en         (en),
      .lz_en      (lz_en),
      .dp_mask    (dp_mask),
      .digit_in   (digit_in),
      .sel        (sel),
      .seg        (seg),
      .dp         (dp),
      .an         (an),
      .frame_tick (frame_tick)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic logic [6:0] seg_of(input logic [3:0] d);
      case (d)
         4'd0: return 7'h40;  4'd1: return 7'h79;  4'd2: return 7'h24;
         4'd3: return 7'h30;  4'd4: return 7'h19;  4'd5: return 7'h12;
         4'd6: return 7'h02;  4'd7: return 7'h78;  4'd8: return 7'h00;
         4'd9: return 7'h10;  4'hF: return 7'h7F;
         default: return 7'h3F;
      endcase
   endfunction

   // Expected {sel,an,seg,dp,frame_tick} t cycles after scanning (re)starts
   function automatic logic [19:0] model(input int t);
      int slot, pos;
      logic [7:0] a;
      logic [6:0] s;
      logic d, ft, supp;
      slot = (t / SD) % 8;
      pos  = t % SD;
      ft   = (t > 0) && (t % (8 * SD) == 0);
      if (pos < BC) begin
         a = 8'hFF; s = 7'h7F; d = 1'b1;
      end else begin
         supp = lz_en && (slot != 7);
         for (int j = 0; j <= slot; j++)
            if (digits[j] != 4'd0) supp = 1'b0;
         a = ~(8'd1 << slot);
         s = supp ? 7'h7F : seg_of(digits[slot]);
         d = ~dp_mask[slot];
      end
      return {3'(slot), a, s, d, ft};
   endfunction

   task automatic restart();
      en = 1'b0;
      @(negedge clk);
      en = 1'b1;
   endtask

   task automatic test_reset();
      logic [19:0] got;
      rst = 1'b1; en = 1'b1; lz_en = 1'b0; dp_mask = 8'h00;
      digits = '{4'd9, 4'd8, 4'd7, 4'd6, 4'd5, 4'd4, 4'd3, 4'd2};
      repeat (2) @(negedge clk);
      #1 got = {sel, an, seg, dp, frame_tick};
      checks++;
      if (got !== RESET_VEC) begin
         failures++;
         $display("FAIL reset_state got=%h exp=%h", got, RESET_VEC);
      end
      @(negedge clk);
      rst = 1'b0;
      for (int t = 0; t < 24; t++) begin
         #1 got = {sel, an, seg, dp, frame_tick};
         checks++;
         if (got !== model(t)) begin
            failures++;
            $display("FAIL reset_release t=%0d got=%h exp=%h", t, got, model(t));
         end
         @(negedge clk);
      end
   endtask

   task automatic test_scan();
      logic [19:0] got;
      digits = '{4'd1, 4'd2, 4'd3, 4'd4, 4'd5, 4'd6, 4'd7, 4'd8};
      lz_en = 1'b0; dp_mask = 8'h00;
      restart();
      for (int t = 0; t < 2 * 8 * SD + 4; t++) begin
         #1 got = {sel, an, seg, dp, frame_tick};
         checks++;
         if (got !== model(t)) begin
            failures++;
            $display("FAIL scan t=%0d got=%h exp=%h", t, got, model(t));
         end
         @(negedge clk);
      end
   endtask

   task automatic test_lz();
      logic [19:0] got;
      digits = '{4'd0, 4'd0, 4'd0, 4'd5, 4'd0, 4'd0, 4'd0, 4'd0};
      lz_en = 1'b1; dp_mask = 8'h00;
      restart();
      for (int t = 0; t < 2 * 8 * SD + 4; t++) begin
         #1 got = {sel, an, seg, dp, frame_tick};
         checks++;
         if (got !== model(t)) begin
            failures++;
            $display("FAIL lz t=%0d got=%h exp=%h", t, got, model(t));
         end
         @(negedge clk);
      end
   endtask

   task automatic test_zero_and_blank();
      logic [19:0] got;
      for (int k = 0; k < 2; k++) begin
         for (int i = 0; i < 8; i++) digits[i] = (k == 0) ? 4'd0 : 4'hF;
         lz_en = 1'b1; dp_mask = 8'h00;
         restart();
         for (int t = 0; t < 8 * SD + 2; t++) begin
            #1 got = {sel, an, seg, dp, frame_tick};
            checks++;
            if (got !== model(t)) begin
               failures++;
               $display("FAIL zero_blank k=%0d t=%0d got=%h exp=%h", k, t, got, model(t));
            end
            @(negedge clk);
         end
      end
   endtask

   task automatic test_dp();
      logic [19:0] got;
      for (int i = 0; i < 8; i++) digits[i] = 4'($urandom_range(0, 15));
      lz_en = 1'b0; dp_mask = 8'b0010_1000;
      restart();
      for (int t = 0; t < 8 * SD + 2; t++) begin
         #1 got = {sel, an, seg, dp, frame_tick};
         checks++;
         if (got !== model(t)) begin
            failures++;
            $display("FAIL dp t=%0d got=%h exp=%h", t, got, model(t));
         end
         @(negedge clk);
      end
   endtask

   task automatic test_random();
      logic [19:0] got;
      for (int r = 0; r < 6; r++) begin
         for (int i = 0; i < 8; i++)
            digits[i] = ($urandom_range(0, 2) == 0) ? 4'($urandom_range(0, 15)) : 4'd0;
         lz_en   = 1'($urandom_range(0, 1));
         dp_mask = 8'($urandom);
         restart();
         for (int t = 0; t < 8 * SD + 3; t++) begin
            #1 got = {sel, an, seg, dp, frame_tick};
            checks++;
            if (got !== model(t)) begin
               failures++;
               $display("FAIL random r=%0d t=%0d got=%h exp=%h", r, t, got, model(t));
            end
            @(negedge clk);
         end
      end
   endtask

   task automatic test_en_drop();
      logic [19:0] got;
      digits = '{4'd3, 4'd1, 4'd4, 4'd1, 4'd5, 4'd9, 4'd2, 4'd6};
      lz_en = 1'b0; dp_mask = 8'hFF;
      restart();
      for (int t = 0; t < 4 * SD + 4; t++) begin
         #1 got = {sel, an, seg, dp, frame_tick};
         checks++;
         if (got !== model(t)) begin
            failures++;
            $display("FAIL en_pre t=%0d got=%h exp=%h", t, got, model(t));
         end
         @(negedge clk);
      end
      en = 1'b0;
      for (int k = 0; k < 4; k++) begin
         @(negedge clk);
         #1 got = {sel, an, seg, dp, frame_tick};
         checks++;
         if (got !== RESET_VEC) begin
            failures++;
            $display("FAIL en_parked k=%0d got=%h exp=%h", k, got, RESET_VEC);
         end
      end
      @(negedge clk);
      en = 1'b1;
      for (int t = 0; t < 8 * SD + 2; t++) begin
         #1 got = {sel, an, seg, dp, frame_tick};
         checks++;
         if (got !== model(t)) begin
            failures++;
            $display("FAIL en_restart t=%0d got=%h exp=%h", t, got, model(t));
         end
         @(negedge clk);
      end
   endtask

   task automatic test_async_rst();
      logic [19:0] got;
      digits = '{4'd0, 4'd7, 4'd0, 4'd2, 4'd8, 4'd1, 4'd0, 4'd4};
      lz_en = 1'b1; dp_mask = 8'b1010_0101;
      restart();
      for (int t = 0; t < 5 * SD + 4; t++) begin
         #1 got = {sel, an, seg, dp, frame_tick};
         checks++;
         if (got !== model(t)) begin
            failures++;
            $display("FAIL rst_pre t=%0d got=%h exp=%h", t, got, model(t));
         end
         @(negedge clk);
      end
      // Mid-SHOW of slot 5; reset must act before the next rising edge
      #2 rst = 1'b1;
      #1 got = {sel, an, seg, dp, frame_tick};
      checks++;
      if (got !== RESET_VEC) begin
         failures++;
         $display("FAIL async_rst got=%h exp=%h", got, RESET_VEC);
      end
      @(negedge clk);
      rst = 1'b0;
      for (int t = 0; t < 8 * SD + 2; t++) begin
         #1 got = {sel, an, seg, dp, frame_tick};
         checks++;
         if (got !== model(t)) begin
            failures++;
            $display("FAIL rst_resume t=%0d got=%h exp=%h", t, got, model(t));
         end
         @(negedge clk);
      end
   endtask

   initial begin
      test_reset();
      test_scan();
      test_lz();
      test_zero_and_blank();
      test_dp();
      test_random();
      test_en_drop();
      test_async_rst();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

`default_nettype wire
